// File: rtl/calc_result_bcd.sv
// Signed result to sign + BCD digits via a serial shift-add-3 (double-dabble) engine, one bit per clock.
// Optional leading-zero blanking (digits above the most significant nonzero one show as 4'hF): define CALC_BCD_BLANK_EN.
module calc_result_bcd #(
   parameter int WIDTH  = 9,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      result,
   output logic                  busy,
   output logic                  done,
   output logic                  sign,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int          CW   = $clog2(WIDTH + 1);
   localparam int          BW   = 4 * DIGITS;
   localparam int unsigned UDIG = DIGITS;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      FINISH
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [CW-1:0]     count;
   logic [WIDTH-1:0]  mag;
   logic [BW-1:0]     scratch;
   logic [BW-1:0]     adjusted;
   logic [BW-1:0]     final_bcd;
   logic              sign_cap;
   logic              last_shift;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      last_shift = (count == CW'(WIDTH - 1));
      state_nx   = state;
      case (state)
         IDLE:    if (start) state_nx = CONV;
         CONV:    if (last_shift) state_nx = FINISH;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Add-3 correction is applied before the shift so every digit stays a legal BCD value after doubling.
   always_comb begin
      adjusted = scratch;
      for (int unsigned i = 0; i < UDIG; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) begin
            adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
         end
      end
   end

`ifdef CALC_BCD_BLANK_EN
   always_comb begin
      logic        leading;
      int unsigned idx;
      final_bcd = scratch;
      leading   = 1'b1;
      idx       = 0;
      for (int unsigned k = 0; k + 1 < UDIG; k++) begin
         idx = UDIG - 1 - k;
         if (leading && (scratch[4*idx +: 4] == 4'd0)) begin
            final_bcd[4*idx +: 4] = 4'hF;
         end else begin
            leading = 1'b0;
         end
      end
   end
`else
   assign final_bcd = scratch;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         mag      <= '0;
         scratch  <= '0;
         sign_cap <= 1'b0;
         sign     <= 1'b0;
         bcd      <= '0;
         done     <= 1'b0;
      end else begin
         done <= (state == FINISH);
         case (state)
            IDLE: begin
               if (start) begin
                  sign_cap <= result[WIDTH-1];
                  // Two's-complement negate as unsigned: most-negative input maps to 2^(WIDTH-1) without overflow.
                  mag      <= result[WIDTH-1] ? (~result + WIDTH'(1)) : result;
                  scratch  <= '0;
                  count    <= '0;
               end
            end
            CONV: begin
               {scratch, mag} <= {adjusted, mag} << 1;
               count          <= count + CW'(1);
            end
            FINISH: begin
               bcd  <= final_bcd;
               sign <= sign_cap;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_result_bcd.sv
// Self-checking bench for calc_result_bcd: directed handshake/boundary cases plus random values vs a decimal-arithmetic model.
module tb_calc_result_bcd;

   localparam int W = 9;
   localparam int D = 3;

   logic            clk;
   logic            rst;
   logic            start;
   logic [W-1:0]    result;
   logic            busy;
   logic            done;
   logic            sign;
   logic [4*D-1:0]  bcd;

   int vectors;
   int miscompares;

   logic            prev_sign;
   logic [4*D-1:0]  prev_bcd;

   calc_result_bcd #(.WIDTH(W), .DIGITS(D)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .result (result),
      .busy   (busy),
      .done   (done),
      .sign   (sign),
      .bcd    (bcd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Decimal digits of |v| computed with division; optional leading-zero blanking.
   function automatic logic [4*D-1:0] ref_bcd(input int v);
      int m;
      int p;
      logic [4*D-1:0] r;
      logic leading;
      m = (v < 0) ? -v : v;
      p = 1;
      r = '0;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'((m / p) % 10);
         p = p * 10;
      end
`ifdef CALC_BCD_BLANK_EN
      leading = 1'b1;
      for (int i = D - 1; i >= 1; i--) begin
         if (leading && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
         else leading = 1'b0;
      end
`else
      leading = 1'b0;
`endif
      return r;
   endfunction

   // One full conversion with cycle-exact checks. ignored_at > 0 pulses start before that shift edge;
   // chain leaves start asserted with chain_val on the done cycle.
   task automatic run_conv(input int val, input int ignored_at, input int ignored_val,
                           input bit chain, input int chain_val);
      logic [W-1:0]   v;
      logic           exp_sign;
      logic [4*D-1:0] exp_bcd;
      v        = W'(val);
      exp_sign = (val < 0);
      exp_bcd  = ref_bcd(val);
      start  = 1'b1;
      result = v;
      @(posedge clk);
      #1;
      start  = 1'b0;
      result = W'($urandom);
      check("busy_after_accept", 32'(busy), 32'd1);
      check("done_after_accept", 32'(done), 32'd0);
      for (int e = 1; e <= W; e++) begin
         if (e == ignored_at) begin
            start  = 1'b1;
            result = W'(ignored_val);
         end
         @(posedge clk);
         #1;
         start  = 1'b0;
         result = W'($urandom);
         check("busy_conv", 32'(busy), 32'd1);
         check("done_conv", 32'(done), 32'd0);
         check("sign_hold", 32'(sign), 32'(prev_sign));
         check("bcd_hold", 32'(bcd), 32'(prev_bcd));
      end
      @(posedge clk);
      #1;
      check("done_pulse", 32'(done), 32'd1);
      check("busy_done", 32'(busy), 32'd0);
      check("sign", 32'(sign), 32'(exp_sign));
      check("bcd", 32'(bcd), 32'(exp_bcd));
      prev_sign = exp_sign;
      prev_bcd  = exp_bcd;
      if (chain) begin
         start  = 1'b1;
         result = W'(chain_val);
      end else begin
         @(posedge clk);
         #1;
         check("done_low_after", 32'(done), 32'd0);
         check("busy_idle", 32'(busy), 32'd0);
         check("sign_idle", 32'(sign), 32'(prev_sign));
         check("bcd_idle", 32'(bcd), 32'(prev_bcd));
      end
   endtask

   initial begin
      int rv;
      vectors     = 0;
      miscompares = 0;
      prev_sign   = 1'b0;
      prev_bcd    = '0;
      rst    = 1'b1;
      start  = 1'b0;
      result = '0;
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_sign", 32'(sign), 32'd0);
      check("reset_bcd", 32'(bcd), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      run_conv(15, 0, 0, 0, 0);
      run_conv(-12, 0, 0, 0, 0);
      run_conv(-5, 0, 0, 0, 0);
      run_conv(-256, 0, 0, 0, 0);
      run_conv(255, 0, 0, 0, 0);
      run_conv(0, 0, 0, 0, 0);
      run_conv(7, 0, 0, 0, 0);

      // Start while busy is ignored; start on the done cycle is accepted.
      run_conv(7, 3, 99, 1, 99);
      run_conv(99, 0, 0, 0, 0);

      // Asynchronous reset in the middle of a conversion.
      start  = 1'b1;
      result = W'(-8);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_sign", 32'(sign), 32'd0);
      check("abort_bcd", 32'(bcd), 32'd0);
      @(posedge clk);
      #1;
      check("abort_done_hold", 32'(done), 32'd0);
      rst       = 1'b0;
      prev_sign = 1'b0;
      prev_bcd  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", 32'(done), 32'd0);
      run_conv(-8, 0, 0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         rv = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
         if (n % 5 == 2) begin
            run_conv(rv, int'($urandom_range(1, W)), int'($urandom_range(0, 255)), 0, 0);
         end else if (n % 7 == 3) begin
            run_conv(rv, 0, 0, 1, int'($urandom_range(0, 255)));
            run_conv(int'(result), 0, 0, 0, 0);
         end else begin
            run_conv(rv, 0, 0, 0, 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/calc_result_bcd.md
Name: calc_result_bcd

Overview:
- Consumer end of the calculator datapath. Accepts one signed two's-complement `result` word per start pulse.
- Converts its magnitude to BCD digits plus a sign flag, using an iterative shift-add-3 (double-dabble) engine, one bit per clock.
- Sits between the combinational calculator core and the display/readout logic. Holds the last converted value until the next conversion completes.

Parameters:
- WIDTH, 9, width of signed input `result`.
- DIGITS, 3, number of BCD output digits. Legal only if 2^(WIDTH-1) <= 10^DIGITS - 1. Default covers -256..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request conversion of `result`; sampled only in IDLE.
- result  input  WIDTH  signed two's-complement value, sampled on the accepting edge.
- busy  output  1  high while conversion is in progress.
- done  output  1  single-cycle pulse; outputs valid and updated.
- sign  output  1  1 = negative result.
- bcd  output  4*DIGITS  packed digits; [3:0] ones, [7:4] tens, [11:8] hundreds.

Behaviour:
- Reset values (rst=1, asynchronous): state=IDLE, busy=0, done=0, sign=0, bcd=0, internal shift/count registers=0.
- FSM states: IDLE, CONV, FINISH.
- IDLE:
  - On an edge with start=1: capture sign = result[WIDTH-1].
  - Load the WIDTH-bit unsigned magnitude register. Magnitude = result if non-negative, else (~result + 1) taken as unsigned WIDTH bits. Most-negative input (-256) gives magnitude 256, no overflow.
  - Clear the BCD scratch register and bit counter; go to CONV.
- CONV: each edge
  - Add 3 to every scratch digit >= 5.
  - Then shift {scratch, magnitude} left by 1 and increment the counter.
  - After WIDTH shifts, go to FINISH.
- FINISH: one edge copies scratch into `bcd`, latches the captured sign into `sign`, and goes to IDLE.
- Latency: start accepted at edge 0. Edges 1..WIDTH do the shifts. Edge WIDTH+1 updates outputs; done=1 for exactly that one cycle.
  - With WIDTH=9: done high in the cycle after edge 10.
- busy: 1 from after edge 0 through the cycle before done; 0 while done=1.
- start while busy=1: ignored; captured operands unaffected.
- start during the done cycle: accepted (state is IDLE); next done follows WIDTH+2 edges later.
- sign/bcd: change only on the FINISH edge; stable otherwise, including during a subsequent conversion.
- Zero input: sign=0, all digits 0.
- rst mid-conversion: immediate abort; no done pulse; outputs return to reset values.
- `result` is don't-care except on the accepting edge.

Optional Feature:
- Macro: CALC_BCD_BLANK_EN.
- Defined: leading-zero blanking applied at the FINISH edge.
  - Every digit above the most-significant nonzero digit is output as 4'hF (blank code).
  - The ones digit is never blanked; zero shows as F,F,0.
  - sign is unchanged.
- Undefined: leading zeros output as 4'h0; no extra logic.

Test Plan:
- rst pulse, then start with result=15 → busy high 10 cycles; done pulse; sign=0; bcd=12'h015; done low afterwards.
- result=-12 (9'h1F4) → sign=1, bcd=12'h012. result=-5 → sign=1, bcd=12'h005.
- Boundaries: result=-256 (9'h100) → sign=1, bcd=12'h256. result=255 → sign=0, bcd=12'h255. result=0 → sign=0, bcd=12'h000.
- Handshake:
  - start result=7, then start result=99 at cycle 3 → ignored; done gives bcd=12'h007.
  - start result=99 on the done cycle → accepted; second done exactly 11 cycles later with bcd=12'h099.
- Reset mid-operation: start result=-8; assert rst at cycle 4 → busy=0, done stays 0, sign=0, bcd=0; a fresh start afterwards completes normally.
- With CALC_BCD_BLANK_EN: result=7 → bcd=12'hFF7; result=-12 → 12'hF12, sign=1; result=0 → 12'hFF0. Without macro: same inputs → 12'h007, 12'h012, 12'h000.
